// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 32x32 multiply controller.
package mult_seq_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned HALF_W      = 16;
    localparam int unsigned ACC_W       = 64;
    localparam int unsigned OP_W        = 2;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned SHIFT_W     = 2;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned ISSUE_CNT_W = 3;

    localparam logic [OP_W-1:0] OP_MUL    = 2'b00;
    localparam logic [OP_W-1:0] OP_MULXUU = 2'b01;
    localparam logic [OP_W-1:0] OP_MULXSU = 2'b10;
    localparam logic [OP_W-1:0] OP_MULXSS = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        FIXUP = 3'd3,
        RESP  = 3'd4
    } state_e;

    // Shift is carried in units of 16 bits: 0, 1 (16) or 2 (32).
    typedef struct packed {
        logic               valid;
        logic [SHIFT_W-1:0] shift;
    } tag_t;

    // Index 0..3 maps to partial-product shifts 0, 16, 16, 32.
    function automatic logic [SHIFT_W-1:0] shift_code(input logic [IDX_W-1:0] idx);
        return SHIFT_W'(idx[1]) + SHIFT_W'(idx[0]);
    endfunction

    // MUL only needs the low 32 bits, so the hi*hi product is skipped.
    function automatic logic [ISSUE_CNT_W-1:0] issue_count(input logic [OP_W-1:0] op);
        return (op == OP_MUL) ? ISSUE_CNT_W'(3) : ISSUE_CNT_W'(4);
    endfunction

    function automatic logic [HALF_W-1:0] op_half(input logic [DATA_W-1:0] x, input logic hi);
        return hi ? x[DATA_W-1:HALF_W] : x[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/mult_seq_tagpipe.sv
// Delay line tracking which issued partial product emerges from the multiplier cell.
module mult_seq_tagpipe
    import mult_seq_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t pipe_q [LATENCY];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign tag_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequences a 32x32 Nios II-style multiply over one shared registered 16x16 cell.
module mult_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_src1,
    input  logic [DATA_W-1:0] req_src2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [HALF_W-1:0] mul_a,
    output logic [HALF_W-1:0] mul_b,
    output logic              mul_en,
    input  logic [DATA_W-1:0] mul_p
);

    state_e              state_q,     state_d;
    logic [OP_W-1:0]     op_q,        op_d;
    logic [DATA_W-1:0]   a_q,         a_d;
    logic [DATA_W-1:0]   b_q,         b_d;
    logic [ACC_W-1:0]    acc_q,       acc_d;
    logic [IDX_W-1:0]    idx_q,       idx_d;
    logic [CNT_W-1:0]    drain_q,     drain_d;
    logic                mul_en_q,    mul_en_d;
    logic [HALF_W-1:0]   mul_a_q,     mul_a_d;
    logic [HALF_W-1:0]   mul_b_q,     mul_b_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                req_ready_q, req_ready_d;

    tag_t             tag_in, tag_out;
    logic [ACC_W-1:0] corr_a, corr_b, corr;

    assign tag_in.valid = mul_en_q;
    assign tag_in.shift = shift_code(idx_q);

    mult_seq_tagpipe #(.LATENCY(MUL_LATENCY)) u_tagpipe (
        .clk     (clk),
        .reset_n (reset_n),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    // Two's-complement correction of the unsigned product for signed operands.
    assign corr_a = a_q[DATA_W-1] ? {b_q, 32'b0} : '0;
    assign corr_b = b_q[DATA_W-1] ? {a_q, 32'b0} : '0;
    assign corr   = (op_q == OP_MULXSU) ? corr_a :
                    (op_q == OP_MULXSS) ? corr_a + corr_b : '0;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        mul_en_d    = 1'b0;
        mul_a_d     = '0;
        mul_b_d     = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        if (tag_out.valid) begin
            acc_d = acc_q + (ACC_W'(mul_p) << {tag_out.shift, 4'd0});
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d  = ISSUE;
                    op_d     = req_op;
                    a_d      = req_src1;
                    b_d      = req_src2;
                    acc_d    = '0;
                    idx_d    = '0;
                    mul_en_d = 1'b1;
                    mul_a_d  = op_half(req_src1, 1'b0);
                    mul_b_d  = op_half(req_src2, 1'b0);
                end
            end
            ISSUE: begin
                if (ISSUE_CNT_W'(idx_q) == issue_count(op_q) - ISSUE_CNT_W'(1)) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    idx_d    = idx_q + IDX_W'(1);
                    mul_en_d = 1'b1;
                    mul_a_d  = op_half(a_q, idx_d[1]);
                    mul_b_d  = op_half(b_q, idx_d[0]);
                end
            end
            DRAIN: begin
                if (drain_q == CNT_W'(MUL_LATENCY - 1)) begin
                    state_d = FIXUP;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            FIXUP: begin
                acc_d       = acc_q - corr;
                rsp_data_d  = (op_q == OP_MUL) ? acc_d[DATA_W-1:0] : acc_d[ACC_W-1:DATA_W];
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            mul_en_q    <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            mul_en_q    <= mul_en_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign mul_en    = mul_en_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: one instance at latency 1 and one at latency 2, each with a cell model.
module tb_mult_seq_ctrl;
    import mult_seq_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        rsp_ready;
    int          sel;

    logic        v1, v2, rr1, rr2, rv1, rv2, en1, en2;
    logic [31:0] rd1, rd2;
    logic [15:0] a1, b1, a2, b2;
    logic [31:0] p1 = '0, s2 = '0, p2 = '0;

    assign v1 = req_valid && (sel == 0);
    assign v2 = req_valid && (sel == 1);

    mult_seq_ctrl #(.MUL_LATENCY(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_ready(rr1), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_data(rd1), .mul_a(a1), .mul_b(b1), .mul_en(en1), .mul_p(p1)
    );

    mult_seq_ctrl #(.MUL_LATENCY(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .req_valid(v2), .req_ready(rr2), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .rsp_valid(rv2), .rsp_ready(rsp_ready),
        .rsp_data(rd2), .mul_a(a2), .mul_b(b2), .mul_en(en2), .mul_p(p2)
    );

    // Registered 16x16 cells: first stage enabled by mul_en, later stages free-running.
    always @(posedge clk) begin
        if (en1) p1 <= {16'b0, a1} * {16'b0, b1};
        if (en2) s2 <= {16'b0, a2} * {16'b0, b2};
        p2 <= s2;
    end

    logic        rr_m, rv_m, en_m;
    logic [31:0] rd_m;
    logic [63:0] acc_m;
    assign rr_m  = (sel == 1) ? rr2 : rr1;
    assign rv_m  = (sel == 1) ? rv2 : rv1;
    assign en_m  = (sel == 1) ? en2 : en1;
    assign rd_m  = (sel == 1) ? rd2 : rd1;
    assign acc_m = (sel == 1) ? u_dut2.acc_q : u_dut1.acc_q;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          sel;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        int          nen;
        string       name;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Step until rsp_valid; accept happens on the first edge.
    task automatic wait_rsp(input bit keep_valid, output int lat, output int nen);
        lat = 0;
        nen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            lat++;
            if (!keep_valid) begin
                req_valid = 1'b0;
                req_src1  = $urandom;
                req_src2  = $urandom;
            end
            if (en_m) nen++;
            if (rv_m) break;
        end
        if (!rv_m) check("rsp_valid_timeout", 64'(rv_m), 64'd1);
    endtask

    task automatic run_op(input vec_t v);
        int lat, nen;
        sel       = v.sel;
        req_op    = v.op;
        req_src1  = v.a;
        req_src2  = v.b;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        check({v.name, "_ready"}, 64'(rr_m), 64'd1);
        wait_rsp(1'b0, lat, nen);
        check({v.name, "_data"}, 64'(rd_m), 64'(v.exp));
        check({v.name, "_latency"}, 64'(lat), 64'(v.lat));
        check({v.name, "_mul_en_cycles"}, 64'(nen), 64'(v.nen));
        tick();
        check({v.name, "_idle_after"}, {62'b0, rr_m, rv_m}, 64'b10);
    endtask

    initial begin
        int   lat, nen;
        vec_t v;

        vecs[0]  = '{0, OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 6, 3, "mul_l1"};
        vecs[1]  = '{0, OP_MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7, 4, "mulxuu_ones"};
        vecs[2]  = '{0, OP_MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7, 4, "mulxss_m1"};
        vecs[3]  = '{0, OP_MULXSS, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 7, 4, "mulxss_min"};
        vecs[4]  = '{0, OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7, 4, "mulxsu_l1"};
        vecs[5]  = '{1, OP_MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 4, "mulxsu_l2"};
        vecs[6]  = '{1, OP_MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 7, 3, "mul_l2"};
        vecs[7]  = '{0, OP_MULXSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 7, 4, "mulxsu_pos"};
        vecs[8]  = '{0, OP_MULXSS, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 7, 4, "mulxss_neg6"};
        vecs[9]  = '{1, OP_MULXSS, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 8, 4, "mulxss_mix_l2"};
        vecs[10] = '{0, OP_MULXUU, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 7, 4, "mulxuu_shift"};
        vecs[11] = '{0, OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 6, 3, "mul_ones_lo"};

        sel = 0; reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = OP_MUL; req_src1 = '0; req_src2 = '0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        check("reset_l1", {rr1, rv1, rd1, en1, a1, b1}, {1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 16'h0});
        check("reset_l2", {rr2, rv2, rd2, en2, a2, b2}, {1'b1, 1'b0, 32'h0, 1'b0, 16'h0, 16'h0});

        foreach (vecs[i]) run_op(vecs[i]);

        // Backpressure with a second request waiting on req_valid.
        sel = 0; rsp_ready = 1'b0;
        req_op = OP_MUL; req_src1 = 32'h0000_1234; req_src2 = 32'h0000_0010;
        req_valid = 1'b1;
        tick();
        req_src1 = 32'd7; req_src2 = 32'd6;
        wait_rsp(1'b1, lat, nen);
        check("bp_latency", 64'(lat + 1), 64'd6);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", {29'b0, rv_m, rr_m, rd_m}, {29'b0, 1'b1, 1'b0, 32'h0001_2340});
            tick();
        end
        rsp_ready = 1'b1;
        check("bp_handshake", {29'b0, rv_m, rr_m, rd_m}, {29'b0, 1'b1, 1'b0, 32'h0001_2340});
        tick();
        check("bp_idle_gap", {62'b0, rr_m, rv_m}, 64'b10);
        wait_rsp(1'b0, lat, nen);
        check("bp_second_data", 64'(rd_m), 64'h2A);
        check("bp_second_latency", 64'(lat), 64'd6);
        check("bp_second_mul_en", 64'(nen), 64'd3);
        tick();
        check("bp_second_idle", {62'b0, rr_m, rv_m}, 64'b10);

        // Reset in ISSUE idx=2, then immediately a fresh MUL on the same instance.
        for (int s = 0; s < 2; s++) begin
            sel = s; rsp_ready = 1'b1;
            req_op = OP_MULXUU; req_src1 = 32'hFFFF_FFFF; req_src2 = 32'hFFFF_FFFF;
            req_valid = 1'b1;
            tick();
            req_valid = 1'b0;
            tick();
            tick();
            reset_n = 1'b0;
            tick();
            reset_n = 1'b1;
            check("rst_state", {rr_m, rv_m, en_m, acc_m}, {1'b1, 1'b0, 1'b0, 64'h0});
            v = '{s, OP_MUL, 32'd7, 32'd9, 32'h0000_003F, (s == 1) ? 7 : 6, 3, "rst_mul7x9"};
            run_op(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
- Sequencer that computes Nios II-style 32x32 multiplies (mul, mulxuu, mulxsu, mulxss) on one shared, registered 16x16 unsigned multiplier cell. The cell has clock enable and fixed latency.
- Issues 16-bit operand-half pairs one per cycle and accumulates shifted partial products into a 64-bit accumulator.
- Applies signed correction, then returns a 32-bit result over a valid/ready handshake.
- Sits between the CPU execute stage and the multiplier cell, replacing the three-cell parallel arrangement with one cell.

Parameters:
- MUL_LATENCY, 1, cycles from mul_en-qualified issue to mul_p valid (legal 1..2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_op  in  2  00 MUL (low 32), 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS
- req_src1  in  32  operand A
- req_src2  in  32  operand B
- rsp_valid  out  1  result valid
- rsp_ready  in  1  result accepted
- rsp_data  out  32  result
- mul_a  out  16  cell operand A
- mul_b  out  16  cell operand B
- mul_en  out  1  cell clock enable / issue strobe
- mul_p  in  32  cell product, valid MUL_LATENCY cycles after issue

Behaviour:
- Clock and reset: single clock clk; reset_n is synchronous, active-low.
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, mul_en 0, mul_a 0, mul_b 0, acc 0, in-flight valid pipe cleared. req_ready is 1 the cycle after reset deasserts.

States:
- IDLE: req_ready=1. On req_valid: latch op and operands, clear acc, idx=0, go to ISSUE.
- ISSUE: mul_en=1 each cycle. Drive halves by idx: 0 = A[15:0]*B[15:0] (shift 0); 1 = A[15:0]*B[31:16] (shift 16); 2 = A[31:16]*B[15:0] (shift 16); 3 = A[31:16]*B[31:16] (shift 32).
  - N = 3 for MUL, 4 otherwise.
  - Exit to DRAIN after idx N-1.
- DRAIN: lasts MUL_LATENCY cycles, mul_en=0, mul_a/mul_b=0.
- FIXUP: 1 cycle. Signed correction mod 2^64:
  - MULXSU: acc -= A[31] ? B<<32 : 0.
  - MULXSS: acc -= (A[31] ? B<<32 : 0) + (B[31] ? A<<32 : 0).
  - MUL/MULXUU: no change.
  - Then load rsp_data = (op==MUL) ? acc[31:0] : acc[63:32].
- RESP: rsp_valid=1. rsp_data is held stable until rsp_ready, then IDLE next cycle.

Accumulation:
- A valid/shift tag pipe of depth MUL_LATENCY tracks each issue.
- When the tag emerges: acc += zero-extended mul_p << tag shift, 64-bit, carries wrap.
- Products are never dropped.

Timing:
- Accept cycle T. rsp_valid first high at T+N+MUL_LATENCY+2.
- MUL, L=1: T+6. Others, L=1: T+7.
- req_ready=0 from T+1 until the cycle after the RESP handshake. Back-to-back accept requires one IDLE cycle.

Boundary conditions:
- req_valid while busy: ignored, not queued.
- rsp_ready already high on entering RESP: handshake completes that cycle.
- Synchronous reset mid-operation (any state): abandon the operation and clear the tag pipe so late mul_p is discarded. rsp_valid must not assert for the abandoned request.
- Operands are latched at accept, so changing req_src* afterwards has no effect.

Decomposition:
- Package mult_seq_pkg: op encoding localparams (OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS), state encoding (IDLE, ISSUE, DRAIN, FIXUP, RESP), per-index shift constants (0, 16, 16, 32), issue count per op.
- One natural sub-module: mult_seq_tagpipe (parameterised MUL_LATENCY shift register of {valid, shift[1:0]}).
- FSM and accumulator stay in the top module.
- Bench uses a behavioural registered 16x16 cell model with enable and the configured latency.

Test Plan:
- MUL 0x00010003 * 0x00020005, L=1 -> rsp_data 0x000B000F, rsp_valid at T+6, exactly 3 mul_en cycles.
- MULXUU 0xFFFFFFFF * 0xFFFFFFFF -> rsp_data 0xFFFFFFFE, 4 mul_en cycles, rsp_valid at T+7.
- MULXSS 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000; MULXSS 0x80000000 * 0x80000000 -> 0x40000000.
- MULXSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF; repeat with MUL_LATENCY=2 -> same data, rsp_valid at T+8.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 and a new request pending -> rsp_data stable, req_ready=0. The new request is accepted only in the IDLE cycle after the handshake and gets a correct independent result.
- reset_n low for 1 cycle during ISSUE idx=2 -> next cycle IDLE, rsp_valid stays 0, acc 0. A following MUL 7*9 -> 0x0000003F with no contamination from the abandoned request.
